// File: rtl/zed64_kbd_pkg.sv
// Shared types and constants for the hex keypad scanner.
package zed64_kbd_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DB   = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } kbd_state_e;

  // Classification of one complete scan frame.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_e;

  // Column 0 driven low, all others released.
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Next active column: the single low bit walks upward and wraps.
  function automatic logic [3:0] rotate_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/hexkey_scan_if.sv
// Keypad matrix lines plus the key event outputs of the scanner.
interface hexkey_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pressed;
  logic [15:0] value;

  // Keypad / consumer side.
  modport master (
    output row,
    input  col, key_valid, key_code, pressed, value
  );

  // Scanner side.
  modport slave (
    input  row,
    output col, key_valid, key_code, pressed, value
  );
endinterface

// File: rtl/hexkey_colscan.sv
// Column walker: dwell timing, column drive, row synchronizer and the
// per-frame accumulator that classifies each 4-column sweep.
module hexkey_colscan
  import zed64_kbd_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frame_done,
  output frame_res_e frame_result,
  output logic [3:0] frame_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic          dwell_last;
  logic [1:0]    nxt_cnt;
  logic [3:0]    nxt_code;

  assign dwell_last = (dwell == DWELL_LAST);
  assign frame_done = dwell_last && (col_idx == 2'd3);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Dwell counter and column rotation on the last dwell cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dwell   <= '0;
      col     <= COL_RESET;
      col_idx <= 2'd0;
    end else if (dwell_last) begin
      dwell   <= '0;
      col     <= rotate_col(col);
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Fold the current column's row sample into the running frame totals.
  always_comb begin
    nxt_cnt  = acc_cnt;
    nxt_code = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (nxt_cnt != 2'd2) nxt_cnt = nxt_cnt + 2'd1;
        nxt_code = {2'(r), col_idx};
      end
    end
  end

  // Frame classification, valid while frame_done is high.
  always_comb begin
    frame_code = nxt_code;
    case (nxt_cnt)
      2'd0:    frame_result = NONE;
      2'd1:    frame_result = SINGLE;
      default: frame_result = MULTI;
    endcase
  end

  // Accumulator holds totals across columns 0..2 and restarts after column 3.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (dwell_last) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= nxt_cnt;
        acc_code <= nxt_code;
      end
    end
  end

endmodule

// File: rtl/hexkey_scan.sv
// 4x4 hex keypad scanner: frame-based press/release debounce, key strobe
// and a 16-bit shift register of accepted codes in display-driver format.
//
// state | meaning
// IDLE  | no key accepted, waiting for a single-key frame
// DB    | candidate key seen in cnt consecutive frames
// HELD  | key accepted, waiting for an empty frame
// REL   | empty frames counted in cnt, waiting to confirm release
module hexkey_scan
  import zed64_kbd_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  hexkey_scan_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DB   = DB;
  localparam logic [1:0] S_HELD = HELD;
  localparam logic [1:0] S_REL  = REL;

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE);

  logic          frame_done;
  frame_res_e    frame_result;
  logic [3:0]    frame_code;
  logic [3:0]    col;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [15:0]   value;

  hexkey_colscan #(.SCAN_DIV(SCAN_DIV)) u_colscan (
    .clk          (clk),
    .clr_n        (clr_n),
    .row          (bus.row),
    .col          (col),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (frame_code)
  );

  assign cnt_inc = cnt + CW'(1);

  // Debounce FSM, advanced once per frame; emits on the DEBOUNCE-th match.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      value     <= 16'd0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (frame_result == SINGLE) begin
              cand  <= frame_code;
              cnt   <= CW'(1);
              state <= S_DB;
            end
          end
          S_DB: begin
            if (frame_result == SINGLE) begin
              if (frame_code == cand) begin
                if (cnt_inc == DEB_TC) begin
                  key_valid <= 1'b1;
                  key_code  <= cand;
                  value     <= {value[11:0], cand};
                  cnt       <= '0;
                  state     <= S_HELD;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cand <= frame_code;
                cnt  <= CW'(1);
              end
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (frame_result == NONE) begin
              cnt   <= CW'(1);
              state <= S_REL;
            end
          end
          S_REL: begin
            if (frame_result == NONE) begin
              if (cnt_inc == DEB_TC) begin
                cnt   <= '0;
                state <= S_IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              state <= S_HELD;
            end
          end
          default: begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.col       = col;
  assign bus.key_valid = key_valid;
  assign bus.key_code  = key_code;
  assign bus.pressed   = (state == S_HELD) || (state == S_REL);
  assign bus.value     = value;

endmodule

// File: tb/tb_hexkey_scan.sv
// Self-checking bench for hexkey_scan with a 4x4 keypad matrix model.
module tb_hexkey_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk;
  logic        clr_n;
  logic [15:0] keys;

  hexkey_scan_if kif();

  hexkey_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: row r pulled low while column c is driven low and key {r,c} held.
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] model_value = 16'd0;

  typedef struct {
    logic [15:0] keys;
    int          press_f;
    int          rel_f;
    int          n_strobe;
    logic [3:0]  code;
    logic [15:0] value;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_t x;
    model_value = {model_value[11:0], code};
    x.code  = code;
    x.value = model_value;
    sb.push_back(x);
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
  endtask

  task automatic align();
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = kif.col;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (kif.col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = kif.col;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL align: col did not wrap to 1110 within 40 cycles, got %b", kif.col);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int s0;
    s0 = strobes;
    if (v.n_strobe != 0) expect_key(v.code);
    keys = v.keys;
    frames(v.press_f);
    #4;
    check("press_strobes", strobes - s0, v.n_strobe);
    check("press_pressed", kif.pressed, v.n_strobe != 0);
    check("press_code", kif.key_code, v.code);
    check("press_value", kif.value, v.value);
    if (v.n_strobe == 0) check("multi_idle_state", dut.state, 2'd0);
    keys = 16'd0;
    frames(v.rel_f - 1);
    #4;
    check("rel_pressed_before", kif.pressed, v.n_strobe != 0);
    frames(1);
    #4;
    check("rel_pressed_after", kif.pressed, 1'b0);
  endtask

  // Strobe monitor: every key_valid cycle is matched against the scoreboard.
  always @(posedge clk) begin
    #2;
    if (kif.key_valid === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got key_code %0h, expected no strobe", kif.key_code);
      end else begin
        e = sb.pop_front();
        check("strobe_code", kif.key_code, e.code);
        check("strobe_value", kif.value, e.value);
      end
    end
  end

  initial begin
    int         s0;
    logic [3:0] one;
    logic [3:0] exp_col;
    one   = 4'b0001;
    keys  = 16'd0;
    clr_n = 1'b0;

    vecs[0] = '{16'h0200, 10, 3, 1, 4'h9, 16'h0009};
    vecs[1] = '{16'h0042,  5, 3, 0, 4'hC, 16'h009C};
    vecs[2] = '{16'h0002,  4, 3, 1, 4'h1, 16'h09C1};
    vecs[3] = '{16'h0004,  4, 3, 1, 4'h2, 16'h9C12};
    vecs[4] = '{16'h0008,  4, 3, 1, 4'h3, 16'hC123};
    vecs[5] = '{16'h0400,  4, 3, 1, 4'hA, 16'h123A};
    vecs[6] = '{16'h0020,  4, 3, 1, 4'h5, 16'h23A5};

    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (10) @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    check("rst_col", kif.col, 4'b1110);
    check("rst_key_valid", kif.key_valid, 1'b0);
    check("rst_key_code", kif.key_code, 4'h0);
    check("rst_pressed", kif.pressed, 1'b0);
    check("rst_value", kif.value, 16'h0000);

    @(posedge clk);
    #1 clr_n = 1'b1;
    check("col_after_rst", kif.col, 4'b1110);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #2;
      exp_col = ~(one << (((i + 1) / SCAN_DIV) % 4));
      check("col_step", kif.col, exp_col);
    end

    align();
    apply_vec(vecs[0]);

    // Bounce: 2 present, 1 absent, 3 present frames of key C.
    s0 = strobes;
    #1 keys = 16'h1000;
    frames(2);
    #1 keys = 16'h0000;
    frames(1);
    #1 keys = 16'h1000;
    frames(2);
    #4;
    check("bounce_no_early", strobes - s0, 0);
    expect_key(4'hC);
    frames(1);
    #4;
    check("bounce_strobe", strobes - s0, 1);
    check("bounce_value", kif.value, 16'h009C);
    keys = 16'h0000;
    frames(3);
    #4;
    check("bounce_released", kif.pressed, 1'b0);

    for (int i = 1; i < 7; i++) apply_vec(vecs[i]);

    // Reset during DB with cnt=2, key kept held through reset.
    keys = 16'h0080;
    frames(2);
    repeat (5) @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    check("dbrst_key_valid", kif.key_valid, 1'b0);
    check("dbrst_value", kif.value, 16'h0000);
    check("dbrst_pressed", kif.pressed, 1'b0);
    check("dbrst_col", kif.col, 4'b1110);
    check("dbrst_key_code", kif.key_code, 4'h0);
    sb.delete();
    model_value = 16'd0;
    s0 = strobes;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (3 * FRAME - 8) @(posedge clk);
    #4;
    check("dbrst_no_early", strobes - s0, 0);
    check("dbrst_not_pressed", kif.pressed, 1'b0);
    expect_key(4'h7);
    repeat (10) @(posedge clk);
    #4;
    check("dbrst_strobe", strobes - s0, 1);
    check("dbrst_final_value", kif.value, 16'h0007);
    check("dbrst_final_pressed", kif.pressed, 1'b1);
    keys = 16'h0000;
    frames(4);
    #4;
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hexkey_scan.md
# hexkey_scan

Scanner for a 4x4 hex keypad matrix, the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad column low at a time and samples the four row lines. It debounces presses and releases over whole scan frames, then emits each accepted key as a 4-bit code with a one-cycle strobe. Accepted codes are shifted into a 16-bit register whose format matches the display driver's 16-bit hex input, so typed digits can be shown directly.

## Interface
- SCAN_DIV, 1000: clk cycles each column stays active; legal minimum 4.
- DEBOUNCE, 4: consecutive identical frames needed to accept a press or a release; legal minimum 2.
- clk  in  1  system clock.
- clr_n  in  1  reset; one clock, asynchronous assert, active-low.
- row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col  out  4  keypad column drive, active-low, exactly one bit low at all times.
- key_valid  out  1  one-cycle strobe on each accepted press.
- key_code  out  4  code of the last accepted key, equal to {row_idx[1:0], col_idx[1:0]}.
- pressed  out  1  high while an accepted key is held (states HELD and REL).
- value  out  16  shift register of accepted codes; newest key is in [3:0].

## Operation
- Reset values: col=4'b1110, key_valid=0, key_code=0, pressed=0, value=0, state=IDLE, and all counters and accumulators 0.
- row passes through a 2-flop synchronizer before any use.
- A dwell counter counts 0..SCAN_DIV-1. On its last cycle:
  - the synchronized row is sampled for the active column;
  - col rotates 1110→1101→1011→0111→1110.
- Frame: 4 dwells, columns 0..3, i.e. 4*SCAN_DIV cycles. A per-frame accumulator records the number of asserted (low) row bits, saturating at 2, and the code of the last one seen.
- Frame result at the column-3 sample: NONE (0 asserted bits), SINGLE(code) (exactly 1), or MULTI (2 or more).
- FSM, evaluated once per frame end; cnt is the frame counter:
  - IDLE: on SINGLE(k), set cand=k, cnt=1, go to DB. On NONE or MULTI, stay.
  - DB: on SINGLE(cand), cnt+1. When cnt+1==DEBOUNCE, emit and go to HELD. On SINGLE(other), set cand=other, cnt=1. On NONE or MULTI, go to IDLE.
  - HELD: on NONE, set cnt=1 and go to REL. Otherwise stay. A key change while held is ignored.
  - REL: on NONE, cnt+1. When cnt+1==DEBOUNCE, go to IDLE. On SINGLE or MULTI, go to HELD.
- Emit: key_valid=1 for one cycle, key_code<=cand, value<={value[11:0], cand}.
- value wraps: after 4 more keys the oldest nibble is shifted out. No other clear exists besides reset.
- Reset mid-operation: all state is discarded immediately and no strobe is issued.

## Timing
- The synchronizer adds 2 cycles of latency. Sampling on the last dwell cycle therefore requires SCAN_DIV≥4, which covers column settle plus synchronizer delay.
- key_valid, key_code and value update on the clk edge after the frame-end sample that completes the DEBOUNCE-th matching frame.
- Press-to-strobe latency ranges from DEBOUNCE*4*SCAN_DIV+1 to (DEBOUNCE+1)*4*SCAN_DIV+1 cycles after the first synchronized low, depending on frame alignment.
- pressed rises in the same cycle as key_valid. It falls on the frame end that completes DEBOUNCE NONE frames.
- Minimum spacing between strobes is 2*DEBOUNCE frames.

## Structure
- Package zed64_kbd_pkg holds:
  - the state enum (IDLE, DB, HELD, REL);
  - the frame-result encoding (NONE, SINGLE, MULTI);
  - constant COL_RESET=4'b1110.
- Sub-module hexkey_colscan contains the dwell counter, column rotation, row synchronizer and frame accumulator. It outputs frame_done, frame_result and frame_code.
- The top level holds the FSM, debounce counter and output registers.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles. The keypad model pulls row[r] low only while col[c]==0 and key (r,c) is held.
- Reset: assert clr_n=0 mid-cycle → all outputs take their reset values at once and col=1110. After release, col steps 1110,1101,1011,0111 with 4 cycles per step.
- Hold key row2/col1 for 10 frames → exactly one key_valid, key_code=4'h9, value=16'h0009, pressed=1. Release for 3 frames → pressed=0.
- Bounce: key present 2 frames, absent 1 frame, then present 3 frames → a single strobe, occurring only after the final 3-frame run.
- Two keys held together (codes 1 and 6) for 5 frames → no strobe and state stays IDLE. Press and release 1,2,3,A in sequence → value=16'h123A. Then press 5 → value=16'h23A5.
- Assert clr_n=0 during the DB state with cnt=2 → no strobe, value=0, and the key must debounce fully again after reset.
